fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit core. It holds the program counter, fetches one 8-bit instruction per request over the shared memory port, and presents it to the decode stage through a valid/ready handshake. It consumes the decoder's `increment_pc` indication. When that indication is low (a load/store is decoding), fetch yields the shared memory port for one cycle before it requests the next instruction.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 8-bit core.
// Holds the PC, issues one byte read per instruction on the shared memory
// port and hands the byte to decode over a valid/ready handshake. After a
// load/store is accepted (increment_pc=0) one GAP cycle leaves the port to
// the data access.
// Optional feature macro: FETCH_REDIRECT_EN adds redirect/redirect_pc,
// which load a new PC from any state.
module fetch_unit #(
   parameter int                 ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              increment_pc,
`ifdef FETCH_REDIRECT_EN
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
`endif
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic [1:0] {
      S_GAP   = 2'd0,
      S_FETCH = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc_q;
   logic [7:0]        instr_q;
   logic              mem_req_q;
   logic              valid_q;

   // Fetch FSM: state, PC, instruction latch and registered output flags.
   // The flags are written together with the next state so they always
   // equal the state decode (mem_req = FETCH, instr_valid = VALID).
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_GAP;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         mem_req_q <= 1'b0;
         valid_q   <= 1'b0;
      end
`ifdef FETCH_REDIRECT_EN
      else if (redirect) begin
         // Redirect beats ack and accept in the same cycle; both are dropped.
         state     <= S_GAP;
         pc_q      <= redirect_pc;
         mem_req_q <= 1'b0;
         valid_q   <= 1'b0;
      end
`endif
      else begin
         case (state)
            S_GAP: begin
               state     <= S_FETCH;
               mem_req_q <= 1'b1;
            end
            S_FETCH: begin
               if (mem_ack) begin
                  instr_q   <= mem_rdata;
                  state     <= S_VALID;
                  mem_req_q <= 1'b0;
                  valid_q   <= 1'b1;
               end
            end
            S_VALID: begin
               if (instr_ready) begin
                  pc_q    <= pc_q + ADDR_W'(1);
                  valid_q <= 1'b0;
                  if (increment_pc) begin
                     state     <= S_FETCH;
                     mem_req_q <= 1'b1;
                  end else begin
                     state     <= S_GAP;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= S_GAP;
               mem_req_q <= 1'b0;
               valid_q   <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req     = mem_req_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign mem_addr    = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// transaction-level model (has-instruction / owes-a-gap flags plus PC).
// Two instances share all inputs: RESET_PC=0 and RESET_PC=0xFF.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       instr_ready;
   logic       increment_pc;
   logic       redirect;
   logic [7:0] redirect_pc;

   logic       mem_req_a, instr_valid_a;
   logic [7:0] mem_addr_a, instr_a, pc_a;
   logic       mem_req_b, instr_valid_b;
   logic [7:0] mem_addr_b, instr_b, pc_b;

   int checks   = 0;
   int failures = 0;

   // Reference model
   logic [7:0] m_pc, m_pc2, m_instr;
   logic       m_have, m_gap;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req_a), .mem_addr(mem_addr_a),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr_a),
      .instr_valid(instr_valid_a), .instr_ready(instr_ready),
      .increment_pc(increment_pc),
`ifdef FETCH_REDIRECT_EN
      .redirect(redirect), .redirect_pc(redirect_pc),
`endif
      .pc(pc_a)
   );

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_ff (
      .clk(clk), .reset(reset), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr_b),
      .instr_valid(instr_valid_b), .instr_ready(instr_ready),
      .increment_pc(increment_pc),
`ifdef FETCH_REDIRECT_EN
      .redirect(redirect), .redirect_pc(redirect_pc),
`endif
      .pc(pc_b)
   );

   // One clock: model consumes the inputs seen at the edge, then we move to
   // the falling edge where outputs are sampled and new inputs are driven.
   task automatic tick();
      logic redir;
      @(posedge clk);
`ifdef FETCH_REDIRECT_EN
      redir = redirect;
`else
      redir = 1'b0;
`endif
      if (reset) begin
         m_pc = 8'h00; m_pc2 = 8'hFF; m_instr = 8'h00; m_have = 0; m_gap = 1;
      end else if (redir) begin
         m_pc = redirect_pc; m_pc2 = redirect_pc; m_have = 0; m_gap = 1;
      end else if (m_have) begin
         if (instr_ready) begin
            m_pc = m_pc + 8'd1; m_pc2 = m_pc2 + 8'd1;
            m_have = 0; m_gap = !increment_pc;
         end
      end else if (m_gap) begin
         m_gap = 0;
      end else if (mem_ack) begin
         m_instr = mem_rdata; m_have = 1;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      mem_ack = 0; mem_rdata = 8'h00; instr_ready = 0; increment_pc = 1;
      redirect = 0; redirect_pc = 8'h00;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      tick(); tick();
      checks++;
      if (mem_req_a !== 1'b0 || instr_valid_a !== 1'b0 || pc_a !== 8'h00 ||
          mem_addr_a !== 8'h00 || instr_a !== 8'h00) begin
         failures++;
         $display("FAIL reset_state: req=%b valid=%b pc=%h addr=%h instr=%h, want 0 0 00 00 00",
                  mem_req_a, instr_valid_a, pc_a, mem_addr_a, instr_a);
      end
      checks++;
      if (pc_b !== 8'hFF || mem_addr_b !== 8'hFF) begin
         failures++;
         $display("FAIL reset_pc_ff: pc=%h addr=%h, want ff ff", pc_b, mem_addr_b);
      end
   endtask

   task automatic test_first_fetch();
      mem_ack = 1; mem_rdata = 8'h09; instr_ready = 1; increment_pc = 1;
      reset = 0;
      // cycle 1 after reset: GAP
      checks++;
      if (mem_req_a !== 1'b0) begin
         failures++; $display("FAIL gap_after_reset: req=%b want 0", mem_req_a);
      end
      tick();
      checks++;
      if (mem_req_a !== 1'b1 || mem_addr_a !== 8'h00) begin
         failures++;
         $display("FAIL first_req: req=%b addr=%h want 1 00", mem_req_a, mem_addr_a);
      end
      tick();
      checks++;
      if (instr_valid_a !== 1'b1 || instr_a !== 8'h09 || mem_req_a !== 1'b0) begin
         failures++;
         $display("FAIL first_valid: valid=%b instr=%h req=%b want 1 09 0",
                  instr_valid_a, instr_a, mem_req_a);
      end
      tick();
      checks++;
      if (mem_addr_a !== 8'h01 || mem_req_a !== 1'b1) begin
         failures++;
         $display("FAIL second_addr: addr=%h req=%b want 01 1", mem_addr_a, mem_req_a);
      end
      checks++;
      if (mem_addr_b !== 8'h00) begin
         failures++; $display("FAIL pc_wrap: addr=%h want 00", mem_addr_b);
      end
   endtask

   task automatic test_load_gap();
      mem_ack = 1; instr_ready = 1; increment_pc = 1;
      for (int i = 0; i < 40 && !(m_have && m_pc == 8'h05); i++) begin
         mem_rdata = 8'($urandom);
         tick();
      end
      checks++;
      if (!(m_have && m_pc == 8'h05) || instr_valid_a !== 1'b1 || pc_a !== 8'h05) begin
         failures++;
         $display("FAIL reach_pc5: valid=%b pc=%h want 1 05", instr_valid_a, pc_a);
      end
      increment_pc = 0;
      tick();
      increment_pc = 1;
      checks++;
      if (pc_a !== 8'h06 || mem_req_a !== 1'b0 || instr_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL load_gap: pc=%h req=%b valid=%b want 06 0 0", pc_a, mem_req_a, instr_valid_a);
      end
      tick();
      checks++;
      if (mem_req_a !== 1'b1 || mem_addr_a !== 8'h06) begin
         failures++;
         $display("FAIL after_gap: req=%b addr=%h want 1 06", mem_req_a, mem_addr_a);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] held_instr, held_pc;
      instr_ready = 0; mem_ack = 1; mem_rdata = 8'hC3;
      for (int i = 0; i < 10 && !m_have; i++) tick();
      checks++;
      if (!m_have || instr_valid_a !== 1'b1 || instr_a !== 8'hC3) begin
         failures++;
         $display("FAIL bp_enter: valid=%b instr=%h want 1 c3", instr_valid_a, instr_a);
      end
      held_instr = m_instr; held_pc = m_pc;
      for (int i = 0; i < 3; i++) begin
         mem_rdata = 8'($urandom);
         tick();
         checks++;
         if (instr_a !== held_instr || pc_a !== held_pc || mem_req_a !== 1'b0 ||
             instr_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold%0d: instr=%h pc=%h req=%b valid=%b want %h %h 0 1",
                     i, instr_a, pc_a, mem_req_a, instr_valid_a, held_instr, held_pc);
         end
      end
      instr_ready = 1; increment_pc = 1;
      tick();
      checks++;
      if (pc_a !== held_pc + 8'd1 || instr_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: pc=%h valid=%b want %h 0", pc_a, instr_valid_a, held_pc + 8'd1);
      end
   endtask

   task automatic test_reset_midfetch();
      mem_ack = 0; instr_ready = 1; increment_pc = 1;
      for (int i = 0; i < 10 && (m_have || m_gap); i++) tick();
      checks++;
      if (mem_req_a !== 1'b1) begin
         failures++; $display("FAIL midfetch_enter: req=%b want 1", mem_req_a);
      end
      reset = 1; mem_ack = 1; mem_rdata = 8'h5A;
      tick();
      reset = 0; mem_ack = 0;
      checks++;
      if (mem_req_a !== 1'b0 || instr_valid_a !== 1'b0 || pc_a !== 8'h00 || instr_a !== 8'h00) begin
         failures++;
         $display("FAIL reset_midfetch: req=%b valid=%b pc=%h instr=%h want 0 0 00 00",
                  mem_req_a, instr_valid_a, pc_a, instr_a);
      end
   endtask

`ifdef FETCH_REDIRECT_EN
   task automatic test_redirect();
      logic [7:0] prev_instr;
      mem_ack = 0; instr_ready = 1;
      for (int i = 0; i < 10 && (m_have || m_gap); i++) tick();
      prev_instr = instr_a;
      redirect = 1; redirect_pc = 8'h40; mem_ack = 1; mem_rdata = 8'h11;
      tick();
      redirect = 0; mem_ack = 0;
      checks++;
      if (instr_valid_a !== 1'b0 || mem_req_a !== 1'b0 || pc_a !== 8'h40 || instr_a !== prev_instr) begin
         failures++;
         $display("FAIL redirect_ack: valid=%b req=%b pc=%h instr=%h want 0 0 40 %h",
                  instr_valid_a, mem_req_a, pc_a, instr_a, prev_instr);
      end
      tick();
      checks++;
      if (mem_req_a !== 1'b1 || mem_addr_a !== 8'h40 || instr_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL redirect_fetch: req=%b addr=%h valid=%b want 1 40 0",
                  mem_req_a, mem_addr_a, instr_valid_a);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset        = ($urandom_range(0, 99) == 0);
         mem_ack      = ($urandom_range(0, 1) == 1);
         mem_rdata    = 8'($urandom);
         instr_ready  = ($urandom_range(0, 9) < 6);
         increment_pc = ($urandom_range(0, 3) != 0);
`ifdef FETCH_REDIRECT_EN
         redirect     = ($urandom_range(0, 19) == 0);
         redirect_pc  = 8'($urandom);
`endif
         tick();
         checks++;
         if (mem_req_a !== (!m_have && !m_gap) || instr_valid_a !== m_have ||
             pc_a !== m_pc || mem_addr_a !== m_pc || instr_a !== m_instr ||
             mem_addr_b !== m_pc2) begin
            failures++;
            $display("FAIL random_cyc%0d: req=%b valid=%b pc=%h addr=%h instr=%h addr_ff=%h want %b %b %h %h %h %h",
                     i, mem_req_a, instr_valid_a, pc_a, mem_addr_a, instr_a, mem_addr_b,
                     (!m_have && !m_gap), m_have, m_pc, m_pc, m_instr, m_pc2);
         end
      end
      reset = 0; redirect = 0;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      m_pc = 8'h00; m_pc2 = 8'hFF; m_instr = 8'h00; m_have = 0; m_gap = 1;
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_load_gap();
      test_backpressure();
      test_reset_midfetch();
`ifdef FETCH_REDIRECT_EN
      test_redirect();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
